// File: rtl/cache_stream_loader.sv
// Parses the UART byte stream into voxel cache writes: a header selects a full-volume load
// or a one-block shift followed by the newly exposed edge slice.
module cache_stream_loader #(
  parameter int LENGTH = 64,
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [7:0]                uart_data_in,
  input  logic                      uart_valid_in,
  input  logic                      abort_in,
  output logic [$clog2(LENGTH)-1:0] xwrite,
  output logic [$clog2(HEIGHT)-1:0] ywrite,
  output logic [$clog2(WIDTH)-1:0]  zwrite,
  output logic [4:0]                data_out,
  output logic                      write_enable,
  output logic [3:0]                control_input,
  output logic                      control_trigger,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      error_out
);

  localparam int XW = $clog2(LENGTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int ZW = $clog2(WIDTH);
  localparam logic [XW-1:0] X_MAX = XW'(LENGTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);
  localparam logic [ZW-1:0] Z_MAX = ZW'(WIDTH - 1);
  localparam logic [3:0] OP_FULL  = 4'd1;
  localparam logic [3:0] OP_SHIFT = 4'd2;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    STREAM_FULL  = 2'd1,
    STREAM_SLICE = 2'd2
  } state_t;

  state_t        state;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [ZW-1:0] cz;
  logic          fix_x;
  logic          fix_z;

  logic [3:0] op;
  logic [3:0] dir;
  logic       dir_onehot;
  logic       x_last;
  logic       y_last;
  logic       z_last;
  logic       pkt_last;

  assign op  = uart_data_in[7:4];
  assign dir = uart_data_in[3:0];
  assign dir_onehot = (dir == 4'b0001) || (dir == 4'b0010) ||
                      (dir == 4'b0100) || (dir == 4'b1000);

  // A held axis counts as permanently at its last value so the carry ripples past it.
  assign z_last   = fix_z || (cz == Z_MAX);
  assign y_last   = (cy == Y_MAX);
  assign x_last   = fix_x || (cx == X_MAX);
  assign pkt_last = z_last && y_last && x_last;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      cx              <= '0;
      cy              <= '0;
      cz              <= '0;
      fix_x           <= 1'b0;
      fix_z           <= 1'b0;
      xwrite          <= '0;
      ywrite          <= '0;
      zwrite          <= '0;
      data_out        <= '0;
      write_enable    <= 1'b0;
      control_input   <= '0;
      control_trigger <= 1'b0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      error_out       <= 1'b0;
    end else begin
      write_enable    <= 1'b0;
      control_trigger <= 1'b0;
      done_out        <= 1'b0;
      error_out       <= 1'b0;
      if (abort_in) begin
        state    <= IDLE;
        cx       <= '0;
        cy       <= '0;
        cz       <= '0;
        fix_x    <= 1'b0;
        fix_z    <= 1'b0;
        busy_out <= 1'b0;
      end else if (uart_valid_in) begin
        case (state)
          IDLE: begin
            if (op == OP_FULL) begin
              state    <= STREAM_FULL;
              cx       <= '0;
              cy       <= '0;
              cz       <= '0;
              fix_x    <= 1'b0;
              fix_z    <= 1'b0;
              busy_out <= 1'b1;
            end else if (op == OP_SHIFT && dir_onehot) begin
              // The slice being streamed is the face the player just moved toward.
              state           <= STREAM_SLICE;
              control_trigger <= 1'b1;
              control_input   <= dir;
              fix_x           <= dir[0] | dir[1];
              fix_z           <= dir[2] | dir[3];
              cx              <= dir[0] ? X_MAX : '0;
              cy              <= '0;
              cz              <= dir[2] ? Z_MAX : '0;
              busy_out        <= 1'b1;
            end else begin
              error_out <= 1'b1;
            end
          end
          STREAM_FULL, STREAM_SLICE: begin
            write_enable <= 1'b1;
            data_out     <= uart_data_in[4:0];
            xwrite       <= cx;
            ywrite       <= cy;
            zwrite       <= cz;
            if (pkt_last) begin
              done_out <= 1'b1;
              state    <= IDLE;
              busy_out <= 1'b0;
              cx       <= '0;
              cy       <= '0;
              cz       <= '0;
              fix_x    <= 1'b0;
              fix_z    <= 1'b0;
            end else begin
              if (!fix_z) cz <= z_last ? '0 : cz + ZW'(1);
              if (z_last) cy <= y_last ? '0 : cy + YW'(1);
              if (z_last && y_last && !fix_x) cx <= x_last ? '0 : cx + XW'(1);
            end
          end
          default: begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cache_stream_loader.sv
// Directed bench for cache_stream_loader at LENGTH=4, WIDTH=4, HEIGHT=2 with a write scoreboard.
module tb_cache_stream_loader;

  logic       clk;
  logic       rst;
  logic [7:0] uart_data;
  logic       uart_valid;
  logic       abort;
  logic [1:0] xwrite;
  logic [0:0] ywrite;
  logic [1:0] zwrite;
  logic [4:0] data_out;
  logic       write_enable;
  logic [3:0] control_input;
  logic       control_trigger;
  logic       busy_out;
  logic       done_out;
  logic       error_out;

  int tests_run = 0;
  int tests_failed = 0;
  int trig_cnt = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  int wr_cnt = 0;

  // Scoreboard record: {x[1:0], y[0], z[1:0], data[4:0], done}
  logic [10:0] exp_q[$];

  cache_stream_loader #(.LENGTH(4), .WIDTH(4), .HEIGHT(2)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .uart_data_in    (uart_data),
    .uart_valid_in   (uart_valid),
    .abort_in        (abort),
    .xwrite          (xwrite),
    .ywrite          (ywrite),
    .zwrite          (zwrite),
    .data_out        (data_out),
    .write_enable    (write_enable),
    .control_input   (control_input),
    .control_trigger (control_trigger),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .error_out       (error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] rec(input int x, input int y, input int z,
                                      input logic [4:0] d, input logic done);
    logic [1:0] xx;
    logic [0:0] yy;
    logic [1:0] zz;
    xx = x[1:0];
    yy = y[0:0];
    zz = z[1:0];
    return {xx, yy, zz, d, done};
  endfunction

  function automatic logic [31:0] all_outputs();
    return {13'd0, xwrite, ywrite, zwrite, data_out, write_enable, control_input,
            control_trigger, busy_out, done_out, error_out};
  endfunction

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    uart_valid = 1'b1;
    uart_data  = b;
    abort      = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    uart_valid = 1'b0;
    abort      = 1'b0;
  endtask

  // Full load of 32 bytes with value k, except byte 0 which carries 'first'.
  task automatic do_full(input logic [7:0] first);
    logic [7:0] b;
    int d0;
    d0 = done_cnt;
    drive(8'h10);
    for (int k = 0; k < 32; k++) begin
      b = (k == 0) ? first : 8'(k);
      exp_q.push_back(rec(k / 8, (k / 4) % 2, k % 4, b[4:0], k == 31));
      drive(b);
      if (k == 0) check("full_busy", {31'd0, busy_out}, 1);
    end
    idle();
    idle();
    check("full_busy_low", {31'd0, busy_out}, 0);
    check("full_done_count", done_cnt - d0, 1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (control_trigger) trig_cnt++;
      if (error_out) err_cnt++;
      if (done_out) done_cnt++;
      if (control_trigger && write_enable) check("trig_write_overlap", 1, 0);
      if (done_out && !write_enable) check("done_without_write", 1, 0);
      if (write_enable) begin
        wr_cnt++;
        if (exp_q.size() == 0) check("unexpected_write", {21'd0, xwrite, ywrite, zwrite, data_out, done_out}, 0);
        else check("write", {21'd0, xwrite, ywrite, zwrite, data_out, done_out}, {21'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int t0, e0, w0, d0;
    rst = 1'b1;
    uart_valid = 1'b0;
    uart_data = 8'h00;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    rst = 1'b0;

    // Full-volume load
    do_full(8'h00);

    // +X shift: slice at x=3, bits [7:5] of payload ignored
    t0 = trig_cnt;
    d0 = done_cnt;
    drive(8'h21);
    idle();
    check("px_trigger", {31'd0, control_trigger}, 1);
    check("px_dir", {28'd0, control_input}, 32'h1);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(rec(3, k / 4, k % 4, 5'(k), k == 7));
      drive(8'h40 + 8'(k));
    end
    idle();
    idle();
    check("px_trig_count", trig_cnt - t0, 1);
    check("px_dir_hold", {28'd0, control_input}, 32'h1);
    check("px_done_count", done_cnt - d0, 1);
    check("px_busy_low", {31'd0, busy_out}, 0);

    // -Z shift: slice at z=0
    t0 = trig_cnt;
    d0 = done_cnt;
    drive(8'h28);
    idle();
    check("nz_trigger", {31'd0, control_trigger}, 1);
    check("nz_dir", {28'd0, control_input}, 32'h8);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(rec(k / 2, k % 2, 0, 5'(16 + k), k == 7));
      drive(8'h10 + 8'(k));
    end
    idle();
    idle();
    check("nz_trig_count", trig_cnt - t0, 1);
    check("nz_done_count", done_cnt - d0, 1);

    // Rejected headers
    t0 = trig_cnt;
    e0 = err_cnt;
    w0 = wr_cnt;
    drive(8'h23);
    drive(8'h30);
    idle();
    check("bad_err_pulse", {31'd0, error_out}, 1);
    idle();
    idle();
    check("bad_err_count", err_cnt - e0, 2);
    check("bad_no_trigger", trig_cnt - t0, 0);
    check("bad_no_write", wr_cnt - w0, 0);
    check("bad_idle", {31'd0, busy_out}, 0);
    do_full(8'h05);

    // Asynchronous reset mid-packet
    drive(8'h10);
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(rec(k / 8, (k / 4) % 2, k % 4, 5'(k), 1'b0));
      drive(8'(k));
    end
    @(posedge clk);
    #1;
    check("pre_rst_busy", {31'd0, busy_out}, 1);
    check("pre_rst_we", {31'd0, write_enable}, 1);
    #1;
    rst = 1'b1;
    uart_valid = 1'b0;
    #1;
    check("rst_async_outputs", all_outputs(), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    idle();
    do_full(8'h00);

    // Abort together with payload byte 3 of a +X slice
    d0 = done_cnt;
    w0 = wr_cnt;
    drive(8'h21);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(rec(3, 0, k, 5'(k), 1'b0));
      drive(8'(k));
    end
    @(negedge clk);
    uart_valid = 1'b1;
    uart_data  = 8'h03;
    abort      = 1'b1;
    idle();
    idle();
    check("abort_busy_low", {31'd0, busy_out}, 0);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_write_count", wr_cnt - w0, 3);
    check("abort_queue_empty", exp_q.size(), 0);
    do_full(8'hFF);

    repeat (3) idle();
    check("leftover_expected", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
